// File: rtl/switch_mcu_bus_pkg.sv
// Shared MCU bus definitions: AHB htrans/hburst codes, master indices and the
// SRAM arbiter FSM state encoding.
package switch_mcu_bus_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd1;
  localparam logic [1:0] HTRANS_BUSY   = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;

  localparam logic M_IFETCH = 1'b0;
  localparam logic M_LSU    = 1'b1;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCKED = 2'd1,
    BURST  = 2'd2
  } arb_state_e;

  // NONSEQ and SEQ both carry a transfer; IDLE and BUSY do not.
  function automatic logic is_req(input logic [1:0] htrans);
    return htrans[0];
  endfunction

  // True when the beat after this one still belongs to the same burst.
  function automatic logic burst_next(input logic [1:0] htrans, input logic [2:0] hburst);
    return (htrans == HTRANS_SEQ) || (htrans == HTRANS_BUSY) ||
           ((htrans == HTRANS_NONSEQ) && (hburst != HBURST_SINGLE));
  endfunction

endpackage

// File: rtl/switch_mcu_arb_rbuf.sv
// Per-master read-data replay buffer: holds a completed data phase for a
// master that was stalled on its next address phase in the same cycle.
module switch_mcu_arb_rbuf #(
  parameter int DATA_W = 32
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_own_dph,
  input  logic              in_s_hready,
  input  logic              in_m_hready,
  input  logic [DATA_W-1:0] in_s_hrdata,
  input  logic              in_s_hresp,
  output logic [DATA_W-1:0] out_hrdata,
  output logic              out_hresp,
  output logic              out_vld
);

  logic [DATA_W-1:0] rbuf_data;
  logic              rbuf_resp;
  logic              capture;

  assign capture = in_own_dph && in_s_hready && !in_m_hready;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      out_vld   <= 1'b0;
      rbuf_data <= '0;
      rbuf_resp <= 1'b0;
    end else if (capture) begin
      out_vld   <= 1'b1;
      rbuf_data <= in_s_hrdata;
      rbuf_resp <= in_s_hresp;
    end else if (in_m_hready) begin
      out_vld   <= 1'b0;
    end
  end

  always_comb begin
    out_hrdata = '0;
    out_hresp  = 1'b0;
    if (out_vld) begin
      out_hrdata = rbuf_data;
      out_hresp  = rbuf_resp;
    end else if (in_own_dph) begin
      out_hrdata = in_s_hrdata;
      out_hresp  = in_s_hresp;
    end
  end

endmodule

// File: rtl/switch_mcu_sram_arbiter.sv
// Two-master AHB arbiter (M0 ifetch, M1 load/store) in front of the MCU SRAM.
// Optional per-master perf counters under SW_MCU_SRAM_ARB_PERF_EN.
module switch_mcu_sram_arbiter
  import switch_mcu_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int INIT_PRIO = 0
`ifdef SW_MCU_SRAM_ARB_PERF_EN
  , parameter int CNT_W   = 16
`endif
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [ADDR_W-1:0] in_m0_haddr,
  input  logic              in_m0_hwrite,
  input  logic [3:0]        in_m0_hsize,
  input  logic [2:0]        in_m0_hburst,
  input  logic [3:0]        in_m0_hport,
  input  logic [1:0]        in_m0_htrans,
  input  logic              in_m0_hmastlock,
  output logic              out_m0_hready,
  output logic              out_m0_hresp,
  output logic [DATA_W-1:0] out_m0_hrdata,
  input  logic [ADDR_W-1:0] in_m1_haddr,
  input  logic              in_m1_hwrite,
  input  logic [3:0]        in_m1_hsize,
  input  logic [2:0]        in_m1_hburst,
  input  logic [3:0]        in_m1_hport,
  input  logic [1:0]        in_m1_htrans,
  input  logic              in_m1_hmastlock,
  output logic              out_m1_hready,
  output logic              out_m1_hresp,
  output logic [DATA_W-1:0] out_m1_hrdata,
  output logic [ADDR_W-1:0] out_s_haddr,
  output logic              out_s_hwrite,
  output logic [3:0]        out_s_hsize,
  output logic [2:0]        out_s_hburst,
  output logic [3:0]        out_s_hport,
  output logic [1:0]        out_s_htrans,
  output logic              out_s_hmastlock,
  input  logic              in_s_hready,
  input  logic              in_s_hresp,
  input  logic [DATA_W-1:0] in_s_hrdata,
`ifdef SW_MCU_SRAM_ARB_PERF_EN
  input  logic              in_cnt_clr,
  output logic [CNT_W-1:0]  out_m0_grant_cnt,
  output logic [CNT_W-1:0]  out_m1_grant_cnt,
  output logic [CNT_W-1:0]  out_m0_wait_cnt,
  output logic [CNT_W-1:0]  out_m1_wait_cnt,
`endif
  output logic              out_grant,
  output arb_state_e        out_arb_state,
  output logic [1:0]        out_rbuf_vld
);

  localparam logic INIT_IDX = (INIT_PRIO != 0);

  arb_state_e state;
  logic       prio_ptr, grant_q, grant_c;
  logic       dph_vld, dph_own;
  logic [1:0] req, hready, own_dph;
  logic [1:0] w_trans;
  logic [2:0] w_burst;
  logic       w_lock, accept;

  assign req = {is_req(in_m1_htrans), is_req(in_m0_htrans)};

  // Grant only moves in ARB and only on a cycle the slave can take a new address.
  always_comb begin
    grant_c = grant_q;
    if (in_rst) begin
      grant_c = INIT_IDX;
    end else if (state == ARB && in_s_hready) begin
      if (req == 2'b11)  grant_c = prio_ptr;
      else if (req[0])   grant_c = M_IFETCH;
      else if (req[1])   grant_c = M_LSU;
    end
  end

  assign w_trans = grant_c ? in_m1_htrans    : in_m0_htrans;
  assign w_burst = grant_c ? in_m1_hburst    : in_m0_hburst;
  assign w_lock  = grant_c ? in_m1_hmastlock : in_m0_hmastlock;
  assign accept  = in_s_hready && is_req(w_trans);

  assign out_s_haddr     = grant_c ? in_m1_haddr  : in_m0_haddr;
  assign out_s_hwrite    = grant_c ? in_m1_hwrite : in_m0_hwrite;
  assign out_s_hsize     = grant_c ? in_m1_hsize  : in_m0_hsize;
  assign out_s_hburst    = w_burst;
  assign out_s_hport     = grant_c ? in_m1_hport  : in_m0_hport;
  assign out_s_htrans    = in_rst ? HTRANS_IDLE : w_trans;
  assign out_s_hmastlock = w_lock;

  assign own_dph[0] = dph_vld && (dph_own == M_IFETCH);
  assign own_dph[1] = dph_vld && (dph_own == M_LSU);

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      hready[n] = in_rst ||
                  ((!req[n] || (grant_c == 1'(n))) && (!own_dph[n] || in_s_hready));
    end
  end

  assign out_m0_hready = hready[0];
  assign out_m1_hready = hready[1];
  assign out_grant     = grant_c;
  assign out_arb_state = state;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state    <= ARB;
      prio_ptr <= INIT_IDX;
      grant_q  <= INIT_IDX;
      dph_vld  <= 1'b0;
      dph_own  <= M_IFETCH;
    end else begin
      grant_q <= grant_c;
      if (in_s_hready) begin
        dph_vld <= accept;
        dph_own <= grant_c;
      end
      if (state == ARB && in_s_hready && req == 2'b11) prio_ptr <= ~prio_ptr;
      // A lock wins over a burst; a NONSEQ opening a multi-beat burst keeps the owner.
      case (state)
        ARB: begin
          if (in_s_hready) begin
            if (is_req(w_trans) && w_lock)       state <= LOCKED;
            else if (burst_next(w_trans, w_burst)) state <= BURST;
          end
        end
        LOCKED: begin
          if (in_s_hready && !w_lock) state <= ARB;
        end
        BURST: begin
          if (in_s_hready) begin
            if (w_lock)                             state <= LOCKED;
            else if (!burst_next(w_trans, w_burst)) state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  switch_mcu_arb_rbuf #(.DATA_W(DATA_W)) u_rbuf0 (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .in_own_dph  (own_dph[0]),
    .in_s_hready (in_s_hready),
    .in_m_hready (hready[0]),
    .in_s_hrdata (in_s_hrdata),
    .in_s_hresp  (in_s_hresp),
    .out_hrdata  (out_m0_hrdata),
    .out_hresp   (out_m0_hresp),
    .out_vld     (out_rbuf_vld[0])
  );

  switch_mcu_arb_rbuf #(.DATA_W(DATA_W)) u_rbuf1 (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .in_own_dph  (own_dph[1]),
    .in_s_hready (in_s_hready),
    .in_m_hready (hready[1]),
    .in_s_hrdata (in_s_hrdata),
    .in_s_hresp  (in_s_hresp),
    .out_hrdata  (out_m1_hrdata),
    .out_hresp   (out_m1_hresp),
    .out_vld     (out_rbuf_vld[1])
  );

`ifdef SW_MCU_SRAM_ARB_PERF_EN
  logic [CNT_W-1:0] gcnt [2];
  logic [CNT_W-1:0] wcnt [2];
  logic [1:0]       acc_m, wait_m;

  always_comb begin
    acc_m = '0;
    if (accept) acc_m[grant_c] = 1'b1;
    wait_m = req & ~hready;
  end

  always_ff @(posedge in_clk) begin
    for (int n = 0; n < 2; n++) begin
      if (in_rst || in_cnt_clr) begin
        gcnt[n] <= '0;
        wcnt[n] <= '0;
      end else begin
        if (acc_m[n] && (gcnt[n] != '1))  gcnt[n] <= gcnt[n] + 1'b1;
        if (wait_m[n] && (wcnt[n] != '1)) wcnt[n] <= wcnt[n] + 1'b1;
      end
    end
  end

  assign out_m0_grant_cnt = gcnt[0];
  assign out_m1_grant_cnt = gcnt[1];
  assign out_m0_wait_cnt  = wcnt[0];
  assign out_m1_wait_cnt  = wcnt[1];
`endif

endmodule

// File: tb/tb_switch_mcu_sram_arbiter.sv
// Directed vector bench for switch_mcu_sram_arbiter with a one-cycle SRAM model
// whose word w reads back as 32'h5A00_0000 + w.
module tb_switch_mcu_sram_arbiter;
  import switch_mcu_bus_pkg::*;

  localparam logic [1:0] TI = HTRANS_IDLE;
  localparam logic [1:0] TN = HTRANS_NONSEQ;
  localparam logic [1:0] TS = HTRANS_SEQ;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [31:0] m0_haddr, m1_haddr;
  logic        m0_hwrite = 1'b0, m1_hwrite = 1'b0;
  logic [3:0]  m0_hsize = 4'd2, m1_hsize = 4'd1;
  logic [2:0]  m0_hburst, m1_hburst;
  logic [3:0]  m0_hport = 4'd0, m1_hport = 4'd0;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hmastlock, m1_hmastlock;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic [31:0] s_haddr;
  logic        s_hwrite, s_hmastlock;
  logic [3:0]  s_hsize, s_hport;
  logic [2:0]  s_hburst;
  logic [1:0]  s_htrans;
  logic        s_hready = 1'b1;
  logic        s_hresp = 1'b0;
  logic [31:0] s_rdata;
  logic        grant;
  arb_state_e  arb_state;
  logic [1:0]  rbuf_vld;
`ifdef SW_MCU_SRAM_ARB_PERF_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] g0_cnt, g1_cnt, w0_cnt, w1_cnt;
`endif

  switch_mcu_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .INIT_PRIO(0)) dut (
    .in_clk(clk), .in_rst(rst),
    .in_m0_haddr(m0_haddr), .in_m0_hwrite(m0_hwrite), .in_m0_hsize(m0_hsize),
    .in_m0_hburst(m0_hburst), .in_m0_hport(m0_hport), .in_m0_htrans(m0_htrans),
    .in_m0_hmastlock(m0_hmastlock),
    .out_m0_hready(m0_hready), .out_m0_hresp(m0_hresp), .out_m0_hrdata(m0_hrdata),
    .in_m1_haddr(m1_haddr), .in_m1_hwrite(m1_hwrite), .in_m1_hsize(m1_hsize),
    .in_m1_hburst(m1_hburst), .in_m1_hport(m1_hport), .in_m1_htrans(m1_htrans),
    .in_m1_hmastlock(m1_hmastlock),
    .out_m1_hready(m1_hready), .out_m1_hresp(m1_hresp), .out_m1_hrdata(m1_hrdata),
    .out_s_haddr(s_haddr), .out_s_hwrite(s_hwrite), .out_s_hsize(s_hsize),
    .out_s_hburst(s_hburst), .out_s_hport(s_hport), .out_s_htrans(s_htrans),
    .out_s_hmastlock(s_hmastlock),
    .in_s_hready(s_hready), .in_s_hresp(s_hresp), .in_s_hrdata(s_rdata),
`ifdef SW_MCU_SRAM_ARB_PERF_EN
    .in_cnt_clr(cnt_clr),
    .out_m0_grant_cnt(g0_cnt), .out_m1_grant_cnt(g1_cnt),
    .out_m0_wait_cnt(w0_cnt), .out_m1_wait_cnt(w1_cnt),
`endif
    .out_grant(grant), .out_arb_state(arb_state), .out_rbuf_vld(rbuf_vld)
  );

  // One-cycle read latency SRAM; DEAD_BEEF when no read was accepted.
  always @(posedge clk) begin
    if (s_htrans[0] && s_hready && !s_hwrite) s_rdata <= 32'h5A00_0000 + {2'b00, s_haddr[31:2]};
    else                                      s_rdata <= 32'hDEAD_BEEF;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int v, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, v, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [1:0] t0, input logic [31:0] a0, input logic l0, input logic [2:0] b0,
                       input logic [1:0] t1, input logic [31:0] a1, input logic l1);
    m0_htrans = t0; m0_haddr = a0; m0_hmastlock = l0; m0_hburst = b0;
    m1_htrans = t1; m1_haddr = a1; m1_hmastlock = l1; m1_hburst = 3'd0;
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] t0; logic [31:0] a0; logic l0; logic [2:0] b0;
    logic [1:0] t1; logic [31:0] a1; logic l1;
    logic [1:0] e_st; logic [31:0] e_sa; logic e_g; logic e_r0; logic e_r1;
    logic [31:0] e_d0; logic [31:0] e_d1; arb_state_e e_state;
  } vec_t;

  function automatic vec_t mk(input logic r,
                              input logic [1:0] t0, input logic [31:0] a0, input logic l0, input logic [2:0] b0,
                              input logic [1:0] t1, input logic [31:0] a1, input logic l1,
                              input logic [1:0] st, input logic [31:0] sa, input logic g,
                              input logic r0, input logic r1, input logic [31:0] d0, input logic [31:0] d1,
                              input arb_state_e s);
    vec_t v;
    v.rst = r; v.t0 = t0; v.a0 = a0; v.l0 = l0; v.b0 = b0; v.t1 = t1; v.a1 = a1; v.l1 = l1;
    v.e_st = st; v.e_sa = sa; v.e_g = g; v.e_r0 = r0; v.e_r1 = r1;
    v.e_d0 = d0; v.e_d1 = d1; v.e_state = s;
    return v;
  endfunction

  // One cycle of hand-sequence stimulus: apply after the edge, outputs checked at negedge.
  task automatic step(input logic sr, input logic [1:0] t0, input logic [31:0] a0,
                      input logic [1:0] t1, input logic [31:0] a1);
    #1;
    s_hready = sr;
    drive(t0, a0, 1'b0, 3'd0, t1, a1, 1'b0);
    @(negedge clk);
  endtask

  vec_t vt [31];

  initial begin
    //    rst t0  a0      l  b     t1  a1      l1   st  s_haddr g  r0 r1 d0            d1            state
    vt[0]  = mk(1, TI, 32'h00, 0, 3'd0, TI, 32'h00, 0,  TI, 32'h00, 0, 1, 1, 32'h0,        32'h0,        ARB);
    vt[1]  = mk(0, TN, 32'h08, 0, 3'd0, TI, 32'h00, 0,  TN, 32'h08, 0, 1, 1, 32'h0,        32'h0,        ARB);
    vt[2]  = mk(0, TI, 32'h00, 0, 3'd0, TI, 32'h00, 0,  TI, 32'h00, 0, 1, 1, 32'h5A000002, 32'h0,        ARB);
    vt[3]  = mk(1, TI, 32'h00, 0, 3'd0, TI, 32'h00, 0,  TI, 32'h00, 0, 1, 1, 32'h0,        32'h0,        ARB);
    vt[4]  = mk(0, TN, 32'h00, 0, 3'd0, TN, 32'h04, 0,  TN, 32'h00, 0, 1, 0, 32'h0,        32'h0,        ARB);
    vt[5]  = mk(0, TI, 32'h00, 0, 3'd0, TN, 32'h04, 0,  TN, 32'h04, 1, 1, 1, 32'h5A000000, 32'h0,        ARB);
    vt[6]  = mk(0, TI, 32'h00, 0, 3'd0, TI, 32'h00, 0,  TI, 32'h00, 1, 1, 1, 32'h0,        32'h5A000001, ARB);
    vt[7]  = mk(0, TN, 32'h00, 0, 3'd0, TI, 32'h00, 0,  TN, 32'h00, 0, 1, 1, 32'h0,        32'h0,        ARB);
    vt[8]  = mk(0, TN, 32'h04, 0, 3'd0, TN, 32'h10, 0,  TN, 32'h10, 1, 0, 1, 32'h5A000000, 32'h0,        ARB);
    vt[9]  = mk(0, TN, 32'h04, 0, 3'd0, TI, 32'h00, 0,  TN, 32'h04, 0, 1, 1, 32'h5A000000, 32'h5A000004, ARB);
    vt[10] = mk(0, TI, 32'h00, 0, 3'd0, TI, 32'h00, 0,  TI, 32'h00, 0, 1, 1, 32'h5A000001, 32'h0,        ARB);
    vt[11] = mk(0, TI, 32'h00, 0, 3'd0, TN, 32'h20, 1,  TN, 32'h20, 1, 1, 1, 32'h0,        32'h0,        ARB);
    vt[12] = mk(0, TN, 32'h00, 0, 3'd0, TN, 32'h24, 1,  TN, 32'h24, 1, 0, 1, 32'h0,        32'h5A000008, LOCKED);
    vt[13] = mk(0, TN, 32'h00, 0, 3'd0, TN, 32'h28, 1,  TN, 32'h28, 1, 0, 1, 32'h0,        32'h5A000009, LOCKED);
    vt[14] = mk(0, TN, 32'h00, 0, 3'd0, TN, 32'h2C, 1,  TN, 32'h2C, 1, 0, 1, 32'h0,        32'h5A00000A, LOCKED);
    vt[15] = mk(0, TN, 32'h00, 0, 3'd0, TI, 32'h00, 0,  TI, 32'h00, 1, 0, 1, 32'h0,        32'h5A00000B, LOCKED);
    vt[16] = mk(0, TN, 32'h00, 0, 3'd0, TI, 32'h00, 0,  TN, 32'h00, 0, 1, 1, 32'h0,        32'h0,        ARB);
    vt[17] = mk(0, TI, 32'h00, 0, 3'd0, TI, 32'h00, 0,  TI, 32'h00, 0, 1, 1, 32'h5A000000, 32'h0,        ARB);
    vt[18] = mk(0, TN, 32'h40, 0, 3'd3, TN, 32'h80, 0,  TN, 32'h40, 0, 1, 0, 32'h0,        32'h0,        ARB);
    vt[19] = mk(0, TS, 32'h44, 0, 3'd3, TN, 32'h80, 0,  TS, 32'h44, 0, 1, 0, 32'h5A000010, 32'h0,        BURST);
    vt[20] = mk(0, TS, 32'h48, 0, 3'd3, TN, 32'h80, 0,  TS, 32'h48, 0, 1, 0, 32'h5A000011, 32'h0,        BURST);
    vt[21] = mk(0, TS, 32'h4C, 0, 3'd3, TN, 32'h80, 0,  TS, 32'h4C, 0, 1, 0, 32'h5A000012, 32'h0,        BURST);
    vt[22] = mk(0, TI, 32'h00, 0, 3'd0, TN, 32'h80, 0,  TI, 32'h00, 0, 1, 0, 32'h5A000013, 32'h0,        BURST);
    vt[23] = mk(0, TI, 32'h00, 0, 3'd0, TN, 32'h80, 0,  TN, 32'h80, 1, 1, 1, 32'h0,        32'h0,        ARB);
    vt[24] = mk(0, TI, 32'h00, 0, 3'd0, TI, 32'h00, 0,  TI, 32'h00, 1, 1, 1, 32'h0,        32'h5A000020, ARB);
    vt[25] = mk(0, TN, 32'h00, 0, 3'd0, TN, 32'h30, 1,  TN, 32'h30, 1, 0, 1, 32'h0,        32'h0,        ARB);
    vt[26] = mk(1, TN, 32'h00, 0, 3'd0, TN, 32'h34, 1,  TI, 32'h00, 0, 1, 1, 32'h0,        32'h5A00000C, LOCKED);
    vt[27] = mk(0, TI, 32'h00, 0, 3'd0, TI, 32'h00, 0,  TI, 32'h00, 0, 1, 1, 32'h0,        32'h0,        ARB);
    vt[28] = mk(0, TN, 32'h04, 0, 3'd0, TN, 32'h08, 0,  TN, 32'h04, 0, 1, 0, 32'h0,        32'h0,        ARB);
    vt[29] = mk(0, TI, 32'h00, 0, 3'd0, TN, 32'h08, 0,  TN, 32'h08, 1, 1, 1, 32'h5A000001, 32'h0,        ARB);
    vt[30] = mk(0, TI, 32'h00, 0, 3'd0, TI, 32'h00, 0,  TI, 32'h00, 1, 1, 1, 32'h0,        32'h5A000002, ARB);

    drive(TI, 32'h0, 1'b0, 3'd0, TI, 32'h0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 31; i++) begin
      #1;
      rst = vt[i].rst;
      drive(vt[i].t0, vt[i].a0, vt[i].l0, vt[i].b0, vt[i].t1, vt[i].a1, vt[i].l1);
      @(negedge clk);
      chk("s_htrans", i, 32'(s_htrans),  32'(vt[i].e_st));
      chk("grant",    i, 32'(grant),     32'(vt[i].e_g));
      chk("m0_hready", i, 32'(m0_hready), 32'(vt[i].e_r0));
      chk("m1_hready", i, 32'(m1_hready), 32'(vt[i].e_r1));
      chk("m0_hrdata", i, m0_hrdata, vt[i].e_d0);
      chk("m1_hrdata", i, m1_hrdata, vt[i].e_d1);
      chk("arb_state", i, 32'(arb_state), 32'(vt[i].e_state));
      chk("m0_hresp", i, 32'(m0_hresp), 32'h0);
      chk("m1_hresp", i, 32'(m1_hresp), 32'h0);
      if (vt[i].e_st != TI) begin
        chk("s_haddr",  i, s_haddr, vt[i].e_sa);
        chk("s_hsize",  i, 32'(s_hsize), vt[i].e_g ? 32'd1 : 32'd2);
        chk("s_hburst", i, 32'(s_hburst), vt[i].e_g ? 32'd0 : 32'(vt[i].b0));
        chk("s_hmastlock", i, 32'(s_hmastlock), 32'(vt[i].e_g ? vt[i].l1 : vt[i].l0));
        chk("s_hport",  i, 32'(s_hport), 32'h0);
      end
      @(posedge clk);
    end

    // Slave not ready: grant must hold on M1 even though only M0 requests.
    step(1'b0, TN, 32'h00, TI, 32'h00);
    chk("stall_grant", 100, 32'(grant), 32'd1);
    chk("stall_m0_hready", 100, 32'(m0_hready), 32'd0);
    @(posedge clk);
    step(1'b1, TN, 32'h00, TI, 32'h00);
    chk("ready_grant", 101, 32'(grant), 32'd0);
    chk("ready_m0_hready", 101, 32'(m0_hready), 32'd1);
    @(posedge clk);

    // M1 holds priority and steals the next address phase: M0's data goes to the buffer.
    step(1'b1, TN, 32'h04, TN, 32'h08);
    chk("lose_grant", 102, 32'(grant), 32'd1);
    chk("lose_m0_hready", 102, 32'(m0_hready), 32'd0);
    chk("lose_rbuf_vld", 102, 32'(rbuf_vld), 32'd0);
    chk("lose_m0_hrdata", 102, m0_hrdata, 32'h5A000000);
    @(posedge clk);
    step(1'b1, TN, 32'h04, TI, 32'h00);
    chk("replay_grant", 103, 32'(grant), 32'd0);
    chk("replay_rbuf_vld", 103, 32'(rbuf_vld), 32'd1);
    chk("replay_m0_hrdata", 103, m0_hrdata, 32'h5A000000);
    chk("replay_m1_hrdata", 103, m1_hrdata, 32'h5A000002);
    @(posedge clk);
    step(1'b1, TI, 32'h00, TI, 32'h00);
    chk("after_rbuf_vld", 104, 32'(rbuf_vld), 32'd0);
    chk("after_m0_hrdata", 104, m0_hrdata, 32'h5A000001);
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_mcu_sram_arbiter.md
Name: switch_mcu_sram_arbiter

Overview:
Two-master AHB arbiter sharing the single switch_mcu_dummy_sram slave port.
- Master 0 (M0) is the instruction fetch port; master 1 (M1) is the load/store port.
- The block arbitrates address phases and routes the slave's data-phase response back to the owning master.
- It buffers read data for a master that is stalled while its own data phase completes.
- It sits between the MCU core bus ports and the SRAM.

Parameters:
ADDR_W, 32, address width of all haddr ports
DATA_W, 32, read data width
INIT_PRIO, 0, master index that holds round-robin priority after reset
CNT_W, 16, width of the performance counters (optional feature only)

Ports:
in_clk  input  1  clock; all logic is on the rising edge
in_rst  input  1  reset; synchronous, active-high
in_mN_haddr  input  ADDR_W  master N address (N = 0, 1; the same set exists per master)
in_mN_hwrite  input  1  master N write flag
in_mN_hsize  input  4  master N transfer size
in_mN_hburst  input  3  master N burst type
in_mN_hport  input  4  master N protection
in_mN_htrans  input  2  master N transfer type
in_mN_hmastlock  input  1  master N locked-sequence request
out_mN_hready  output  1  master N ready
out_mN_hresp  output  1  master N response
out_mN_hrdata  output  DATA_W  master N read data
out_s_haddr, out_s_hwrite, out_s_hsize, out_s_hburst, out_s_hport, out_s_htrans, out_s_hmastlock  output  (widths as above)  muxed address phase to the slave
in_s_hready  input  1  slave ready
in_s_hresp  input  1  slave response
in_s_hrdata  input  DATA_W  slave read data
out_grant  output  1  index of the current address-phase owner (debug)

Behaviour:
- htrans encoding (codebase convention): 0 IDLE, 1 NONSEQ, 2 BUSY, 3 SEQ. A request means htrans is NONSEQ or SEQ.
- Reset: prio_ptr = INIT_PRIO; grant = INIT_PRIO; dph_vld = 0; rbuf_vld[1:0] = 0; out_mN_hready = 1; out_mN_hresp = 0; out_mN_hrdata = 0; out_s_htrans = IDLE.
- FSM (registered) has three states:
  - ARB: grant is recomputed combinationally every cycle.
  - LOCKED: the granted master has hmastlock = 1.
  - BURST: the granted master drives SEQ or BUSY.
- Transitions:
  - ARB -> LOCKED when the winner drives hmastlock = 1.
  - ARB -> BURST when the winner's next beat is SEQ/BUSY.
  - LOCKED -> ARB when the owner drops hmastlock with in_s_hready = 1.
  - BURST -> ARB when the owner drives IDLE or NONSEQ with in_s_hready = 1.
  - A lock has precedence over a burst.
- Arbitration in ARB:
  - Only one master requests: it wins.
  - Both request: the master selected by prio_ptr wins, then prio_ptr flips to the other master.
  - No requests: grant holds and out_s_htrans = IDLE.
  - The grant changes only when in_s_hready = 1.
- Slave address phase: the granted master's signals pass to out_s_* combinationally. A non-granted master never reaches the slave.
- Stall: a requesting master that is not granted gets out_mN_hready = 0 and must hold its address; it is served in a later cycle.
- Data phase tracking: when a request is accepted (in_s_hready = 1), set dph_vld = 1 and dph_own = grant for the next cycle. Read latency is one cycle, so the slave data arrives in cycle N+1.
- Response routing:
  - Data owner with no buffered read: out_hrdata/out_hresp come directly from the slave.
  - If the data owner's out_hready = 0 in that cycle (its new request lost), capture in_s_hrdata/in_s_hresp into rbuf_N and set rbuf_vld[N] = 1.
  - While rbuf_vld[N] = 1, out_mN_hrdata/hresp come from rbuf_N.
  - rbuf_vld[N] clears on the first cycle with out_mN_hready = 1.
- out_mN_hready = 1 when (master N is not requesting, or is granted) and (master N owns no data phase, or in_s_hready = 1).
- Non-owner outputs: out_hrdata = 0 and out_hresp = 0 for a master that owns no data phase and has no valid buffer.
- Edge cases:
  - Reset asserted mid-burst or mid-lock aborts to ARB and drops all buffers.
  - A lock owner that stops requesting still blocks the other master until it deasserts hmastlock.
  - Simultaneous NONSEQ from both masters on the cycle prio_ptr is reset serves INIT_PRIO first.

Optional Feature:
SW_MCU_SRAM_ARB_PERF_EN
- Defined: adds per-master saturating counters, CNT_W bits each:
  - out_mN_grant_cnt: accepted transfers.
  - out_mN_wait_cnt: cycles with out_mN_hready = 0 while requesting.
  - in_cnt_clr (1 bit) clears all counters synchronously; reset also clears them.
  - Counters saturate at all-ones.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package switch_mcu_bus_pkg:
  - htrans constants HTRANS_IDLE / NONSEQ / BUSY / SEQ.
  - arbiter FSM state encoding ARB / LOCKED / BURST.
  - master index constants M_IFETCH = 0, M_LSU = 1.
- One sub-module: switch_mcu_arb_rbuf, the per-master read-data replay buffer, instantiated twice.

Test Plan:
- M0 only reads addr 0x8 (NONSEQ, hsize 2) -> out_s_haddr = 0x8 the same cycle; out_m0_hrdata = sram[2] next cycle; out_m0_hready stays 1.
- Both masters issue NONSEQ in cycle 1 after reset (INIT_PRIO = 0), M0 addr 0x0, M1 addr 0x4:
  - Cycle 1: M0 wins; out_m1_hready = 0.
  - Cycle 2: M1 is granted; M0 gets sram[0].
  - Cycle 3: M1 gets sram[1].
- M0 back-to-back reads 0x0 then 0x4 while M1 holds priority and requests 0x10 -> M0 data sram[0] is buffered and replayed when out_m0_hready = 1; the value matches exactly.
- M1 asserts hmastlock for 4 transfers while M0 requests continuously -> out_grant = 1 for all 4; out_m0_hready = 0 throughout; M0 is granted the cycle after hmastlock falls.
- M0 4-beat burst (NONSEQ then SEQ ×3) with M1 requesting -> no grant switch until M0 drives IDLE; then M1 is served.
- Reset asserted mid-lock -> next cycle out_s_htrans = 0, both hready = 1, out_grant = INIT_PRIO, rbuf_vld = 0.
